// File: rtl/multicycle_ctrl_if.sv
// Decode inputs and datapath/memory control outputs of the multicycle MIPS controller.
// The controller drives through "master"; whoever supplies op/zero/mem_ready uses "slave".
interface multicycle_ctrl_if;
   logic [5:0] op;
   logic       zero;
   logic       mem_ready;
   logic       mem_req;
   logic       mem_we;
   logic       iord;
   logic       ir_we;
   logic       pc_en;
   logic [1:0] pcsrc;
   logic       alusrc_a;
   logic [1:0] alusrc_b;
   logic [1:0] aluop;
   logic       regdst;
   logic       memtoreg;
   logic       reg_we;
   logic       retire;
   logic       illegal;
   logic       mem_err;
   logic [3:0] state;

   modport master (
      input  op, zero, mem_ready,
      output mem_req, mem_we, iord, ir_we, pc_en, pcsrc, alusrc_a, alusrc_b, aluop,
             regdst, memtoreg, reg_we, retire, illegal, mem_err, state
   );

   modport slave (
      output op, zero, mem_ready,
      input  mem_req, mem_we, iord, ir_we, pc_en, pcsrc, alusrc_a, alusrc_b, aluop,
             regdst, memtoreg, reg_we, retire, illegal, mem_err, state
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath with illegal-op trap and memory watchdog.
// Datapath controls are registered from the next state; only ir_we, pc_en and retire look at inputs.
module multicycle_ctrl #(
   parameter bit ILLEGAL_TRAP = 1'b1,
   parameter int MEM_TIMEOUT  = 0,
   parameter int CNT_W        = 8
) (
   input logic               clk,
   input logic               resetn,
   multicycle_ctrl_if.master bus
);
   typedef enum logic [3:0] {
      S_IDLE   = 4'h0,
      S_FETCH  = 4'h1,
      S_DECODE = 4'h2,
      S_MEMADR = 4'h3,
      S_MEMRD  = 4'h4,
      S_MEMWB  = 4'h5,
      S_MEMWR  = 4'h6,
      S_RTEXE  = 4'h7,
      S_ALUWB  = 4'h8,
      S_IEXE   = 4'h9,
      S_IWB    = 4'hA,
      S_BRANCH = 4'hB,
      S_JUMP   = 4'hC,
      S_HALT   = 4'hF
   } state_t;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic [1:0] pcsrc;
      logic       alusrc_a;
      logic [1:0] alusrc_b;
      logic [1:0] aluop;
      logic       regdst;
      logic       memtoreg;
      logic       reg_we;
   } ctrl_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam bit             WDOG_EN  = (MEM_TIMEOUT > 0);
   localparam logic [CNT_W-1:0] TMO_LAST = WDOG_EN ? CNT_W'(MEM_TIMEOUT - 1) : '0;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             illegal_q, illegal_d;
   logic             memErr_q, memErr_d;
   ctrl_t            ctrl_q;
   logic             opKnown;
   logic             memWait;

   function automatic ctrl_t ctrlFor(state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH:  c.alusrc_b = 2'b01;
         S_DECODE: c.alusrc_b = 2'b11;
         S_MEMADR: begin c.alusrc_a = 1'b1; c.alusrc_b = 2'b10; end
         S_MEMWB:  begin c.reg_we = 1'b1; c.memtoreg = 1'b1; end
         S_RTEXE:  begin c.alusrc_a = 1'b1; c.aluop = 2'b10; end
         S_ALUWB:  begin c.reg_we = 1'b1; c.regdst = 1'b1; end
         S_IEXE:   begin c.alusrc_a = 1'b1; c.alusrc_b = 2'b10; c.aluop = 2'b11; end
         S_IWB:    c.reg_we = 1'b1;
         S_BRANCH: begin c.alusrc_a = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; end
         S_JUMP:   c.pcsrc = 2'b10;
         default:  ;
      endcase
      c.mem_req = (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
      c.iord    = (s == S_MEMRD) || (s == S_MEMWR);
      c.mem_we  = (s == S_MEMWR);
      return c;
   endfunction

   always_comb begin
      opKnown = (bus.op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI})
             || (bus.op[5:2] == 4'b0011);
      memWait = (state_q inside {S_FETCH, S_MEMRD, S_MEMWR}) && !bus.mem_ready;
   end

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      memErr_d  = memErr_q;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            if (!opKnown) begin
               illegal_d = 1'b1;
               state_d   = ILLEGAL_TRAP ? S_HALT : S_FETCH;
            end else if (bus.op == OP_RTYPE) begin
               state_d = S_RTEXE;
            end else if ((bus.op == OP_LW) || (bus.op == OP_SW)) begin
               state_d = S_MEMADR;
            end else if (bus.op == OP_BEQ) begin
               state_d = S_BRANCH;
            end else if (bus.op == OP_J) begin
               state_d = S_JUMP;
            end else begin
               state_d = S_IEXE;
            end
         end
         S_MEMADR: state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
         S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
         S_RTEXE:  state_d = S_ALUWB;
         S_IEXE:   state_d = S_IWB;
         S_MEMWB, S_ALUWB, S_IWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_HALT;
      endcase
      // A ready in the final allowed wait cycle still wins, since memWait is then false.
      if (WDOG_EN && memWait && (cnt_q == TMO_LAST)) begin
         memErr_d = 1'b1;
         state_d  = S_HALT;
      end
      cnt_d = (WDOG_EN && memWait && (state_d == state_q)) ? cnt_q + 1'b1 : '0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         memErr_q  <= 1'b0;
         ctrl_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
         memErr_q  <= memErr_d;
         ctrl_q    <= ctrlFor(state_d);
      end
   end

   always_comb begin
      bus.mem_req  = ctrl_q.mem_req;
      bus.mem_we   = ctrl_q.mem_we;
      bus.iord     = ctrl_q.iord;
      bus.pcsrc    = ctrl_q.pcsrc;
      bus.alusrc_a = ctrl_q.alusrc_a;
      bus.alusrc_b = ctrl_q.alusrc_b;
      bus.aluop    = ctrl_q.aluop;
      bus.regdst   = ctrl_q.regdst;
      bus.memtoreg = ctrl_q.memtoreg;
      bus.reg_we   = ctrl_q.reg_we;
      bus.illegal  = illegal_q;
      bus.mem_err  = memErr_q;
      bus.state    = state_q;
      bus.ir_we    = (state_q == S_FETCH) && bus.mem_ready;
      bus.pc_en    = ((state_q == S_FETCH) && bus.mem_ready)
                  || ((state_q == S_BRANCH) && bus.zero)
                  || (state_q == S_JUMP);
      bus.retire   = (state_q inside {S_MEMWB, S_ALUWB, S_IWB, S_BRANCH, S_JUMP})
                  || ((state_q == S_MEMWR) && bus.mem_ready)
                  || ((state_q == S_DECODE) && !ILLEGAL_TRAP && !opKnown);
   end
endmodule
